// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the 5-stage RV32I pipeline.
//
// Decodes the IF/ID instruction, drives the register-file read addresses,
// resolves both source operands (EX/MEM and WB forwarding plus the
// same-cycle WB write bypass), detects hazards that need a stall, builds the
// sign-extended immediate and registers the result into ID/EX.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   if_valid/if_pc/if_instr    IF/ID slot contents
//   flush                      redirect from EX; kills the instruction in ID
//   rf_rs*_addr / rf_rs*_data  register-file read port (data combinational)
//   exmem_*                    destination info of the instruction in EX/MEM
//   wb_*                       register-file write port (also the bypass source)
//   stall                      hold PC and IF/ID this cycle
//   idex_*                     ID/EX pipeline register outputs
//
// Parameter FWD_EN: 1 forwards from EX/MEM and WB; 0 stalls on any RAW hazard
// against an in-flight writer (the WB bypass is still applied).
module id_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        flush,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    input  logic        exmem_wen,
    input  logic        exmem_is_load,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_value,
    input  logic        wb_wen,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_value,
    output logic        stall,
    output logic        idex_valid,
    output logic [31:0] idex_pc,
    output logic [31:0] idex_rs1_val,
    output logic [31:0] idex_rs2_val,
    output logic [31:0] idex_imm,
    output logic [4:0]  idex_rd,
    output logic [6:0]  idex_opcode,
    output logic [2:0]  idex_funct3,
    output logic        idex_funct7b5,
    output logic        idex_is_load,
    output logic        idex_wen
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_used, rs2_used;
    logic        rs1_hz, rs2_hz;
    logic        dec_wen, dec_is_load;
    logic [31:0] rs1_val, rs2_val, imm;

    assign opcode      = if_instr[6:0];
    assign rs1         = if_instr[19:15];
    assign rs2         = if_instr[24:20];
    assign rd          = if_instr[11:7];
    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    assign rs1_used    = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign rs2_used    = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);
    assign dec_is_load = (opcode == OP_LOAD);
    assign dec_wen     = (rd != 5'd0) && (opcode != OP_STORE) && (opcode != OP_BRANCH);

    // Operand resolution. Loads in EX/MEM are never forwarded: their value is
    // not ready yet and the hazard logic stalls instead.
    always_comb begin
        rs1_val = rf_rs1_data;
        if (rs1 == 5'd0)
            rs1_val = '0;
        else if (FWD_EN && exmem_wen && !exmem_is_load && exmem_rd == rs1)
            rs1_val = exmem_value;
        else if (wb_wen && wb_rd == rs1)
            rs1_val = wb_value;
    end

    always_comb begin
        rs2_val = rf_rs2_data;
        if (rs2 == 5'd0)
            rs2_val = '0;
        else if (FWD_EN && exmem_wen && !exmem_is_load && exmem_rd == rs2)
            rs2_val = exmem_value;
        else if (wb_wen && wb_rd == rs2)
            rs2_val = wb_value;
    end

    // With forwarding only loads cause hazards (the load in ID/EX and then in
    // EX/MEM, giving two bubbles); without it every in-flight writer does.
    always_comb begin
        rs1_hz = 1'b0;
        rs2_hz = 1'b0;
        if (FWD_EN) begin
            rs1_hz = (idex_valid && idex_is_load && idex_rd == rs1) ||
                     (exmem_wen && exmem_is_load && exmem_rd == rs1);
            rs2_hz = (idex_valid && idex_is_load && idex_rd == rs2) ||
                     (exmem_wen && exmem_is_load && exmem_rd == rs2);
        end else begin
            rs1_hz = (idex_valid && idex_wen && idex_rd == rs1) ||
                     (exmem_wen && exmem_rd == rs1);
            rs2_hz = (idex_valid && idex_wen && idex_rd == rs2) ||
                     (exmem_wen && exmem_rd == rs2);
        end
    end

    assign stall = !reset && !flush && if_valid &&
                   ((rs1_used && rs1 != 5'd0 && rs1_hz) ||
                    (rs2_used && rs2 != 5'd0 && rs2_hz));

    always_comb begin
        imm = '0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR:
                imm = {{20{if_instr[31]}}, if_instr[31:20]};
            OP_STORE:
                imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            OP_BRANCH:
                imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                       if_instr[30:25], if_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {if_instr[31:12], 12'b0};
            OP_JAL:
                imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                       if_instr[20], if_instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

    // Flush and stall both leave a bubble; payload fields simply hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_valid    <= 1'b0;
            idex_pc       <= '0;
            idex_rs1_val  <= '0;
            idex_rs2_val  <= '0;
            idex_imm      <= '0;
            idex_rd       <= '0;
            idex_opcode   <= '0;
            idex_funct3   <= '0;
            idex_funct7b5 <= 1'b0;
            idex_is_load  <= 1'b0;
            idex_wen      <= 1'b0;
        end else if (flush || stall) begin
            idex_valid    <= 1'b0;
            idex_is_load  <= 1'b0;
            idex_wen      <= 1'b0;
        end else begin
            idex_valid    <= if_valid;
            idex_pc       <= if_pc;
            idex_rs1_val  <= rs1_val;
            idex_rs2_val  <= rs2_val;
            idex_imm      <= imm;
            idex_rd       <= rd;
            idex_opcode   <= opcode;
            idex_funct3   <= if_instr[14:12];
            idex_funct7b5 <= if_instr[30];
            idex_is_load  <= if_valid && dec_is_load;
            idex_wen      <= if_valid && dec_wen;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed table-driven bench for id_stage, plus hand-written
// multi-cycle sequences (reset, load-use, flush, reset mid-stall, FWD_EN=0).
// Instance u_fwd uses FWD_EN=1, u_nofwd uses FWD_EN=0; both share inputs.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        exmem_wen, exmem_is_load;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_value;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value;

    logic [4:0]  a_rs1_addr, a_rs2_addr, b_rs1_addr, b_rs2_addr;
    logic        a_stall, a_valid, a_funct7b5, a_is_load, a_wen;
    logic        b_stall, b_valid, b_funct7b5, b_is_load, b_wen;
    logic [31:0] a_pc, a_rs1, a_rs2, a_imm, b_pc, b_rs1, b_rs2, b_imm;
    logic [4:0]  a_rd, b_rd;
    logic [6:0]  a_op, b_op;
    logic [2:0]  a_f3, b_f3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_stage #(.FWD_EN(1'b1)) u_fwd (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .flush(flush),
        .rf_rs1_addr(a_rs1_addr), .rf_rs2_addr(a_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .exmem_wen(exmem_wen), .exmem_is_load(exmem_is_load),
        .exmem_rd(exmem_rd), .exmem_value(exmem_value),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_value(wb_value),
        .stall(a_stall), .idex_valid(a_valid), .idex_pc(a_pc),
        .idex_rs1_val(a_rs1), .idex_rs2_val(a_rs2), .idex_imm(a_imm),
        .idex_rd(a_rd), .idex_opcode(a_op), .idex_funct3(a_f3),
        .idex_funct7b5(a_funct7b5), .idex_is_load(a_is_load), .idex_wen(a_wen)
    );

    id_stage #(.FWD_EN(1'b0)) u_nofwd (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .flush(flush),
        .rf_rs1_addr(b_rs1_addr), .rf_rs2_addr(b_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .exmem_wen(exmem_wen), .exmem_is_load(exmem_is_load),
        .exmem_rd(exmem_rd), .exmem_value(exmem_value),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_value(wb_value),
        .stall(b_stall), .idex_valid(b_valid), .idex_pc(b_pc),
        .idex_rs1_val(b_rs1), .idex_rs2_val(b_rs2), .idex_imm(b_imm),
        .idex_rd(b_rd), .idex_opcode(b_op), .idex_funct3(b_f3),
        .idex_funct7b5(b_funct7b5), .idex_is_load(b_is_load), .idex_wen(b_wen)
    );

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic [31:0] rf1, rf2;
        logic        ex_wen, ex_ld;
        logic [4:0]  ex_rd;
        logic [31:0] ex_val;
        logic        wb_w;
        logic [4:0]  wb_r;
        logic [31:0] wb_v;
        logic        e_stall, e_valid, chk_data;
        logic [31:0] e_rs1, e_rs2, e_imm;
        logic [4:0]  e_rd;
        logic        e_wen, e_ld;
        logic [6:0]  e_op;
        logic [2:0]  e_f3;
        logic        e_f7;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic v,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic exw, input logic exl, input logic [4:0] exr,
                         input logic [31:0] exv, input logic ww, input logic [4:0] wr,
                         input logic [31:0] wv, input logic fl);
        if_instr = instr; if_valid = v; if_pc = 32'h0000_1000 + {instr[11:0], 2'b00};
        rf_rs1_data = r1; rf_rs2_data = r2;
        exmem_wen = exw; exmem_is_load = exl; exmem_rd = exr; exmem_value = exv;
        wb_wen = ww; wb_rd = wr; wb_value = wv; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // addi x5,x0,-1 ; rs1=x0 must read 0 despite rf data
        vt[0]  = '{32'hFFF00293, 1, 32'hDEAD, 32'h2222, 0,0,5'd0,0, 0,5'd0,0,
                   0,1,1, 32'h0, 32'h2222, 32'hFFFFFFFF, 5'd5, 1,0, 7'h13,3'd0,1};
        // add x3,x1,x2 ; x1 from EX/MEM, x2 from WB
        vt[1]  = '{32'h002081B3, 1, 32'h1, 32'h2, 1,0,5'd1,32'h10, 1,5'd2,32'h20,
                   0,1,1, 32'h10, 32'h20, 32'h0, 5'd3, 1,0, 7'h33,3'd0,0};
        // EX/MEM beats WB on the same register
        vt[2]  = '{32'h002081B3, 1, 32'h1, 32'h2, 1,0,5'd1,32'h10, 1,5'd1,32'h99,
                   0,1,1, 32'h10, 32'h2, 32'h0, 5'd3, 1,0, 7'h33,3'd0,0};
        // WB beats register file when EX/MEM targets another register
        vt[3]  = '{32'h002081B3, 1, 32'h1, 32'h2, 1,0,5'd9,32'h10, 1,5'd1,32'h99,
                   0,1,1, 32'h99, 32'h2, 32'h0, 5'd3, 1,0, 7'h33,3'd0,0};
        // load in EX/MEM feeding rs2 -> stall, bubble
        vt[4]  = '{32'h002081B3, 1, 32'h1, 32'h2, 1,1,5'd2,32'h10, 0,5'd0,0,
                   1,0,0, 32'h0, 32'h0, 32'h0, 5'd0, 0,0, 7'h0,3'd0,0};
        // sw x2,-4(x1)
        vt[5]  = '{32'hFE20AE23, 1, 32'h100, 32'h200, 0,0,5'd0,0, 0,5'd0,0,
                   0,1,1, 32'h100, 32'h200, 32'hFFFFFFFC, 5'd28, 0,0, 7'h23,3'd2,1};
        // beq x1,x2,+8
        vt[6]  = '{32'h00208463, 1, 32'h3, 32'h4, 0,0,5'd0,0, 0,5'd0,0,
                   0,1,1, 32'h3, 32'h4, 32'h8, 5'd8, 0,0, 7'h63,3'd0,0};
        // beq x0,x0,-2 ; WB write to x0 must not leak
        vt[7]  = '{32'hFE000FE3, 1, 32'h11, 32'h22, 0,0,5'd0,0, 1,5'd0,32'h77,
                   0,1,1, 32'h0, 32'h0, 32'hFFFFFFFE, 5'd31, 0,0, 7'h63,3'd0,1};
        // lui x7,0x12345 ; unused rs1 (x8) matches a load in EX/MEM -> no stall
        vt[8]  = '{32'h123453B7, 1, 32'h55, 32'h66, 1,1,5'd8,32'hBAD, 0,5'd0,0,
                   0,1,1, 32'h55, 32'h66, 32'h12345000, 5'd7, 1,0, 7'h37,3'd5,0};
        // jal x1,-4
        vt[9]  = '{32'hFFDFF0EF, 1, 32'h55, 32'h66, 0,0,5'd0,0, 0,5'd0,0,
                   0,1,1, 32'h55, 32'h66, 32'hFFFFFFFC, 5'd1, 1,0, 7'h6F,3'd7,1};
        // invalid slot with a load hazard: no stall, fields loaded, wen gated
        vt[10] = '{32'h002081B3, 0, 32'h7, 32'h8, 1,1,5'd1,32'hBAD, 0,5'd0,0,
                   0,0,1, 32'h7, 32'h8, 32'h0, 5'd3, 0,0, 7'h33,3'd0,0};
        // sub x0,x1,x2 ; rd=0 never writes
        vt[11] = '{32'h40208033, 1, 32'h5, 32'h6, 0,0,5'd0,0, 1,5'd1,32'hAB,
                   0,1,1, 32'hAB, 32'h6, 32'h0, 5'd0, 0,0, 7'h33,3'd0,1};
        // lw x6,-8(x2)
        vt[12] = '{32'hFF812303, 1, 32'h40, 32'h66, 0,0,5'd0,0, 0,5'd0,0,
                   0,1,1, 32'h40, 32'h66, 32'hFFFFFFF8, 5'd6, 1,1, 7'h03,3'd2,1};

        // Reset held two cycles with a valid, would-stall instruction present
        reset = 1'b1;
        drive(32'h002081B3, 1, 1, 2, 1, 1, 5'd1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("reset%0d stall", i), {31'b0, a_stall}, 32'd0);
            tick();
            chk($sformatf("reset%0d valid", i), {31'b0, a_valid}, 32'd0);
            chk($sformatf("reset%0d imm", i), a_imm, 32'd0);
        end
        reset = 1'b0;
        drive(32'h00000013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].instr, vt[i].valid, vt[i].rf1, vt[i].rf2, vt[i].ex_wen,
                  vt[i].ex_ld, vt[i].ex_rd, vt[i].ex_val, vt[i].wb_w, vt[i].wb_r,
                  vt[i].wb_v, 1'b0);
            #1;
            chk($sformatf("v%0d stall", i), {31'b0, a_stall}, {31'b0, vt[i].e_stall});
            tick();
            chk($sformatf("v%0d valid", i), {31'b0, a_valid}, {31'b0, vt[i].e_valid});
            chk($sformatf("v%0d wen", i), {31'b0, a_wen}, {31'b0, vt[i].e_wen});
            chk($sformatf("v%0d is_load", i), {31'b0, a_is_load}, {31'b0, vt[i].e_ld});
            if (vt[i].chk_data) begin
                chk($sformatf("v%0d rs1", i), a_rs1, vt[i].e_rs1);
                chk($sformatf("v%0d rs2", i), a_rs2, vt[i].e_rs2);
                chk($sformatf("v%0d imm", i), a_imm, vt[i].e_imm);
                chk($sformatf("v%0d rd", i), {27'b0, a_rd}, {27'b0, vt[i].e_rd});
                chk($sformatf("v%0d opcode", i), {25'b0, a_op}, {25'b0, vt[i].e_op});
                chk($sformatf("v%0d funct3", i), {29'b0, a_f3}, {29'b0, vt[i].e_f3});
                chk($sformatf("v%0d f7b5", i), {31'b0, a_funct7b5}, {31'b0, vt[i].e_f7});
            end
        end

        // Load-use: lw x6,0(x2) then add x7,x6,x6 -> two bubbles, then WB value
        do_reset();
        drive(32'h00012303, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("lu lw is_load", {31'b0, a_is_load}, 32'd1);
        drive(32'h006303B3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("lu rs1_addr", {27'b0, a_rs1_addr}, 32'd6);
        chk("lu rs2_addr", {27'b0, a_rs2_addr}, 32'd6);
        chk("lu c1 stall", {31'b0, a_stall}, 32'd1);
        tick();
        chk("lu c1 valid", {31'b0, a_valid}, 32'd0);
        drive(32'h006303B3, 1, 0, 0, 1, 1, 5'd6, 0, 0, 0, 0, 0);
        #1;
        chk("lu c2 stall", {31'b0, a_stall}, 32'd1);
        tick();
        chk("lu c2 valid", {31'b0, a_valid}, 32'd0);
        drive(32'h006303B3, 1, 0, 0, 0, 0, 0, 0, 1, 5'd6, 32'h1234, 0);
        #1;
        chk("lu c3 stall", {31'b0, a_stall}, 32'd0);
        tick();
        chk("lu c3 valid", {31'b0, a_valid}, 32'd1);
        chk("lu c3 rs1", a_rs1, 32'h1234);
        chk("lu c3 rs2", a_rs2, 32'h1234);
        chk("lu c3 rd", {27'b0, a_rd}, 32'd7);

        // lw x6 then lui x6,1: no source used, no stall
        drive(32'h00012303, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(32'h00001337, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("lui stall", {31'b0, a_stall}, 32'd0);
        tick();
        chk("lui valid", {31'b0, a_valid}, 32'd1);
        chk("lui imm", a_imm, 32'h0000_1000);

        // lw x6 then beq x0,x6 with flush: flush beats stall
        drive(32'h00012303, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(32'h00600063, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("flush stall", {31'b0, a_stall}, 32'd0);
        tick();
        chk("flush valid", {31'b0, a_valid}, 32'd0);
        chk("flush is_load", {31'b0, a_is_load}, 32'd0);
        // flush of a clean instruction also kills it
        drive(32'hFFF00293, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("flush2 valid", {31'b0, a_valid}, 32'd0);
        chk("flush2 wen", {31'b0, a_wen}, 32'd0);

        // Reset mid-stall: stall drops in the same cycle, pipeline restarts empty
        drive(32'h00012303, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(32'h006303B3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rms stall pre", {31'b0, a_stall}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rms stall in reset", {31'b0, a_stall}, 32'd0);
        tick();
        chk("rms valid", {31'b0, a_valid}, 32'd0);
        chk("rms is_load", {31'b0, a_is_load}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rms stall after", {31'b0, a_stall}, 32'd0);
        tick();
        chk("rms resume valid", {31'b0, a_valid}, 32'd1);

        // FWD_EN=0: addi x1,x0,5 then add x4,x1,x0 -> two stalls, WB bypass
        do_reset();
        drive(32'h00500093, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("nf addi wen", {31'b0, b_wen}, 32'd1);
        drive(32'h00008233, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("nf c1 stall", {31'b0, b_stall}, 32'd1);
        tick();
        chk("nf c1 valid", {31'b0, b_valid}, 32'd0);
        drive(32'h00008233, 1, 0, 0, 1, 0, 5'd1, 32'd5, 0, 0, 0, 0);
        #1;
        chk("nf c2 stall", {31'b0, b_stall}, 32'd1);
        chk("fwd c2 no stall", {31'b0, a_stall}, 32'd0);
        tick();
        chk("nf c2 valid", {31'b0, b_valid}, 32'd0);
        drive(32'h00008233, 1, 0, 0, 0, 0, 0, 0, 1, 5'd1, 32'd5, 0);
        #1;
        chk("nf c3 stall", {31'b0, b_stall}, 32'd0);
        tick();
        chk("nf c3 valid", {31'b0, b_valid}, 32'd1);
        chk("nf c3 rs1", b_rs1, 32'd5);
        chk("nf c3 rd", {27'b0, b_rd}, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage RV32I pipeline.
- Drives the register-file read addresses and receives the combinational read data.
- Applies EX/MEM and WB forwarding and the same-cycle WB write bypass; detects load-use hazards; generates immediates.
- Registers everything into the ID/EX pipeline register consumed by the execute stage.

Parameters:
- FWD_EN, 1, 1: forward from EX/MEM and WB. 0: stall on any RAW hazard against an in-flight writer instead of forwarding.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- if_valid  in  1  IF/ID slot holds a real instruction
- if_pc  in  32  PC of IF/ID instruction
- if_instr  in  32  IF/ID instruction word
- flush  in  1  branch/jump redirect from EX; kill ID contents
- rf_rs1_addr  out  5  register-file read address 1 (instr[19:15])
- rf_rs2_addr  out  5  register-file read address 2 (instr[24:20])
- rf_rs1_data  in  32  register-file read data 1 (combinational)
- rf_rs2_data  in  32  register-file read data 2
- exmem_wen  in  1  EX/MEM instruction writes rd
- exmem_is_load  in  1  EX/MEM instruction is a load (value not yet valid)
- exmem_rd  in  5  EX/MEM destination
- exmem_value  in  32  EX/MEM ALU result
- wb_wen  in  1  WB write enable (same signal as register-file write port)
- wb_rd  in  5  WB destination
- wb_value  in  32  WB write data
- stall  out  1  hold PC and IF/ID this cycle
- idex_valid  out  1  ID/EX slot valid
- idex_pc  out  32  ID/EX PC
- idex_rs1_val  out  32  resolved operand 1
- idex_rs2_val  out  32  resolved operand 2
- idex_imm  out  32  sign-extended immediate
- idex_rd  out  5  destination register
- idex_opcode  out  7  instr[6:0]
- idex_funct3  out  3  instr[14:12]
- idex_funct7b5  out  1  instr[30]
- idex_is_load  out  1  opcode 0000011
- idex_wen  out  1  writes rd (rd != 0 and opcode is not STORE or BRANCH)

Behaviour:
- Reset: synchronous, active-high. All idex_* outputs clear to 0. stall is combinational and is 0 whenever reset or flush is high.
- rf_rs*_addr: pure slices of if_instr. No register.
- Register usage:
  - rs1 is used unless opcode is LUI (0110111), AUIPC (0010111) or JAL (1101111).
  - rs2 is used only for R (0110011), STORE (0100011) and BRANCH (1100011).
  - Unused sources never cause a stall.
- Operand priority, per source, when FWD_EN=1:
  1. Address 0: always 0.
  2. exmem_wen && exmem_rd==addr && !exmem_is_load: exmem_value.
  3. wb_wen && wb_rd==addr: wb_value. This covers the register-file write landing at the same posedge.
  4. Otherwise: rf data.
- Load-use stall: stall=1 when a used source (non-zero address) matches either of:
  - idex_valid && idex_is_load && idex_rd;
  - exmem_wen && exmem_is_load && exmem_rd.
  Resulting load-to-use penalty is 2 bubbles.
- FWD_EN=0: stall=1 when a used source (non-zero address) matches idex_rd (idex_valid && idex_wen) or exmem_rd (exmem_wen). The WB write bypass (priority 3) still applies.
- Immediates, sign-extended from instr[31]:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - Any other opcode: imm = 0.
- Per-posedge update of ID/EX, in priority order:
  1. reset: clear.
  2. flush: idex_valid=0, idex_wen=0, idex_is_load=0. Other fields don't-care (hold). Flush overrides stall.
  3. stall: insert bubble (idex_valid=0, idex_wen=0, idex_is_load=0). IF/ID is held externally, so the same instruction is re-evaluated next cycle.
  4. Otherwise: load all fields. idex_valid=if_valid. idex_wen and idex_is_load are ANDed with if_valid.
- stall is qualified by if_valid: an invalid IF/ID slot never stalls.
- Latency: 1 cycle from IF/ID to ID/EX.
- Reset mid-stall: the pipeline restarts empty and stall drops the same cycle.

Test Plan:
- Reset asserted 2 cycles with if_valid=1 -> idex_valid=0, idex_imm=0, stall=0 throughout.
- addi x5,x0,-1 (0xFFF00293) -> next cycle idex_imm=0xFFFFFFFF, idex_rd=5, idex_wen=1, idex_rs1_val=0 even if rf_rs1_data=0xDEAD.
- add x3,x1,x2 with rf x1=1, x2=2; exmem writes x1=0x10; wb writes x2=0x20 -> idex_rs1_val=0x10, idex_rs2_val=0x20. If exmem and wb both target x1 (0x10 / 0x99) -> idex_rs1_val=0x10.
- lw x6,0(x2) followed by add x7,x6,x6 -> stall=1 for 2 cycles with bubbles (idex_valid=0). Third cycle takes x6 from wb_value=0x1234; idex_rs1_val=idex_rs2_val=0x1234.
- lw x6 in ID/EX, next instruction lui x6,1 (rs unused) -> no stall. beq x0,x6 with load-use on x6 plus flush=1 -> stall=0, idex_valid=0.
- FWD_EN=0: add x4,x1,x0 after addi x1 in ID/EX -> stall=1 for 2 cycles. Third cycle reads wb_value via the bypass.
